cpu_controller: RTL and testbench

Instruction sequencer for the RISC CPU. It steps a fixed 8-phase cycle per instruction and decodes the current phase, the instruction opcode and the ALU zero flag into the datapath control strobes: address mux select, memory read/write, IR load, PC increment/load, data bus enable, and `ld_ac` for the accumulator register. Each instruction takes exactly 8 clocks; `HLT` freezes the machine until reset.

---
 rtl/cpu_controller_if.sv | 26 ++
 rtl/cpu_controller.sv | 115 +++++++++++
 tb/tb_cpu_controller.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cpu_controller_if.sv
// Control bundle between the instruction sequencer and the CPU datapath.
// master = sequencer (drives strobes), slave = datapath (drives opcode/zero).
interface cpu_controller_if;
    logic [2:0] opcode;
    logic       zero;
    logic       sel;
    logic       rd;
    logic       wr;
    logic       ld_ir;
    logic       inc_pc;
    logic       ld_pc;
    logic       data_e;
    logic       ld_ac;
    logic       halt;
    logic [2:0] phase;

    modport master (
        input  opcode, zero,
        output sel, rd, wr, ld_ir, inc_pc, ld_pc, data_e, ld_ac, halt, phase
    );

    modport slave (
        output opcode, zero,
        input  sel, rd, wr, ld_ir, inc_pc, ld_pc, data_e, ld_ac, halt, phase
    );
endinterface

// File: rtl/cpu_controller.sv
// RISC CPU instruction sequencer: fixed 8-phase cycle per instruction,
// decoding phase/opcode/zero into datapath strobes. HLT freezes until reset.
module cpu_controller (
    input logic                clk,
    input logic                rst,
    cpu_controller_if.master   bus
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    phase_t phase_q, phase_d;
    logic   halted_q, halted_d;
    logic   is_aluop, is_skz, is_sto, is_jmp;

    assign is_aluop = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
                      (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);
    assign is_skz   = (bus.opcode == OP_SKZ);
    assign is_sto   = (bus.opcode == OP_STO);
    assign is_jmp   = (bus.opcode == OP_JMP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // Halting parks the counter at OP_ADDR; the wrap 7->0 is the natural 3-bit overflow.
    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (phase_q == OP_ADDR && bus.opcode == OP_HLT)
                halted_d = 1'b1;
            else
                phase_d = phase_t'(phase_q + 3'd1);
        end
    end

    always_comb begin
        bus.sel    = 1'b0;
        bus.rd     = 1'b0;
        bus.wr     = 1'b0;
        bus.ld_ir  = 1'b0;
        bus.inc_pc = 1'b0;
        bus.ld_pc  = 1'b0;
        bus.data_e = 1'b0;
        bus.ld_ac  = 1'b0;
        bus.halt   = 1'b0;
        if (halted_q) begin
            bus.halt = 1'b1;
        end else begin
            case (phase_q)
                INST_ADDR: begin
                    bus.sel = 1'b1;
                end
                INST_FETCH: begin
                    bus.sel = 1'b1;
                    bus.rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    bus.sel   = 1'b1;
                    bus.rd    = 1'b1;
                    bus.ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    bus.inc_pc = 1'b1;
                    bus.halt   = (bus.opcode == OP_HLT);
                end
                OP_FETCH: begin
                    bus.rd = is_aluop;
                end
                ALU_OP: begin
                    // Second increment on a taken SKZ skips the next instruction.
                    bus.rd     = is_aluop;
                    bus.inc_pc = is_skz & bus.zero;
                    bus.ld_pc  = is_jmp;
                    bus.data_e = is_sto;
                end
                STORE: begin
                    bus.rd     = is_aluop;
                    bus.ld_ac  = is_aluop;
                    bus.ld_pc  = is_jmp;
                    bus.wr     = is_sto;
                    bus.data_e = is_sto;
                end
                default: ;
            endcase
        end
    end

    assign bus.phase = phase_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed plus randomized check of cpu_controller against a phase-rule model.
module tb_cpu_controller;

    logic clk;
    logic rst;
    cpu_controller_if bus ();

    cpu_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Reference state: phase as a plain integer count mod 8, plus halted flag.
    int m_ph = 0;
    bit m_h  = 1'b0;

    // {sel,rd,wr,ld_ir,inc_pc,ld_pc,data_e,ld_ac,halt,phase[2:0]}
    function automatic logic [11:0] expect_vec(int ph, int op, bit z, bit h);
        bit alu, sel, rd, wr, ldir, inc, ldpc, de, ldac, hl;
        logic [2:0] p;
        if (h) return {9'b0_0000_0001, 3'd4};
        alu  = (op >= 2 && op <= 5);
        sel  = (ph <= 3);
        rd   = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
        ldir = (ph == 2 || ph == 3);
        inc  = (ph == 4) || (ph == 6 && op == 1 && z);
        ldpc = (op == 7) && (ph >= 6);
        de   = (op == 6) && (ph >= 6);
        wr   = (op == 6) && (ph == 7);
        ldac = alu && (ph == 7);
        hl   = (ph == 4) && (op == 0);
        p    = 3'(ph);
        return {sel, rd, wr, ldir, inc, ldpc, de, ldac, hl, p};
    endfunction

    task automatic check(input string tag);
        logic [11:0] obs, exp;
        obs = {bus.sel, bus.rd, bus.wr, bus.ld_ir, bus.inc_pc, bus.ld_pc,
               bus.data_e, bus.ld_ac, bus.halt, bus.phase};
        exp = expect_vec(m_ph, int'(bus.opcode), bus.zero, m_h);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s ph=%0d op=%0d observed=%b expected=%b",
                   tag, m_ph, bus.opcode, obs, exp);
        end
    endtask

    // Advance one clock and update the model; returns 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_ph = 0;
            m_h  = 1'b0;
        end else if (!m_h) begin
            if (m_ph == 4 && bus.opcode == 3'd0) m_h = 1'b1;
            else m_ph = (m_ph + 1) % 8;
        end
        #1;
    endtask

    // zmode: 0/1 fixed zero flag, 2 random each cycle. rnd_early scrambles opcode in phases 0-3.
    task automatic run_instr(input int op, input int zmode, input bit rnd_early, input string tag);
        for (int i = 0; i < 8; i++) begin
            if (rnd_early && !m_h && m_ph < 4) bus.opcode = 3'($urandom_range(0, 7));
            else bus.opcode = 3'(op);
            bus.zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            #2;
            check(tag);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.opcode = 3'd0;
        bus.zero = 1'b0;
        #2;
        check("reset");
        @(negedge clk);
        rst = 1'b0;
        check("post_reset_ph0");

        run_instr(5, 0, 1'b0, "lda");
        check("lda_wrap");
        run_instr(1, 1, 1'b0, "skz_z1");
        run_instr(1, 0, 1'b0, "skz_z0");
        run_instr(6, 2, 1'b0, "sto");
        run_instr(7, 2, 1'b0, "jmp");

        // ADD aborted by an asynchronous reset in phase 6.
        for (int i = 0; i < 7; i++) begin
            bus.opcode = 3'd2;
            bus.zero = 1'($urandom_range(0, 1));
            #2;
            check("add_pre_rst");
            if (i < 6) tick();
        end
        rst = 1'b1;
        #1;
        m_ph = 0;
        m_h  = 1'b0;
        check("add_async_rst");
        tick();
        #1;
        check("add_rst_held");
        rst = 1'b0;
        run_instr(2, 2, 1'b0, "add_restart");

        for (int n = 0; n < 60; n++)
            run_instr($urandom_range(1, 7), 2, 1'b1, "random");

        run_instr(0, 2, 1'b0, "hlt");
        for (int i = 0; i < 20; i++) begin
            bus.opcode = 3'($urandom_range(0, 7));
            bus.zero = 1'($urandom_range(0, 1));
            #2;
            check("halted");
            tick();
        end
        rst = 1'b1;
        #1;
        m_ph = 0;
        m_h  = 1'b0;
        check("halt_async_rst");
        #2;
        rst = 1'b0;
        tick();
        run_instr(5, 2, 1'b0, "lda_after_halt");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
